// File: rtl/nonce_uart_rx_if.sv
// Bundle of UART receive line and nonce outputs between host link and processor.
// slave is the receiver side, master is the side driving rx and consuming the nonce.
interface nonce_uart_rx_if;
  logic        rx;
  logic [31:0] nonceIn;
  logic        nonceValid;
  logic        frameError;
  logic        busy;

  modport slave (
    input  rx,
    output nonceIn,
    output nonceValid,
    output frameError,
    output busy
  );

  modport master (
    output rx,
    input  nonceIn,
    input  nonceValid,
    input  frameError,
    input  busy
  );
endinterface

// File: rtl/nonce_uart_rx.sv
// 8N1 UART receiver that packs four bytes big-endian into a 32-bit nonce seed.
// Bad stop bits and idle gaps discard any partial word so framing resynchronises.
module nonce_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 289,
  parameter int unsigned GAP_CLKS     = 100000
) (
  input  logic            clock,
  input  logic            reset,
  nonce_uart_rx_if.slave  bus
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned GapW = $clog2(GAP_CLKS + 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CLKS - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          r_state;
  logic [1:0]      r_sync;
  logic [CntW-1:0] r_clk_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_byte;
  logic [23:0]     r_word;
  logic [1:0]      r_byte_count;
  logic [GapW-1:0] r_gap_cnt;
  logic [31:0]     r_nonce;
  logic            r_valid;
  logic            r_ferr;
  logic            w_rxs;

  assign w_rxs = r_sync[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_sync       <= 2'b11;
      r_clk_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_byte       <= '0;
      r_word       <= '0;
      r_byte_count <= '0;
      r_gap_cnt    <= '0;
      r_nonce      <= '0;
      r_valid      <= 1'b0;
      r_ferr       <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], bus.rx};
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (!w_rxs) begin
            r_state   <= StStart;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
          end else if (r_byte_count != 2'd0) begin
            // A stalled partial word is dropped silently so the next byte starts a word.
            if (r_gap_cnt == GapLast) begin
              r_byte_count <= '0;
              r_gap_cnt    <= '0;
            end else begin
              r_gap_cnt <= r_gap_cnt + 1'b1;
            end
          end else begin
            r_gap_cnt <= '0;
          end
        end
        StStart: begin
          if (r_clk_cnt == HalfCnt) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_state   <= w_rxs ? StIdle : StData;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        StData: begin
          if (r_clk_cnt == LastCnt) begin
            r_clk_cnt <= '0;
            r_byte    <= {w_rxs, r_byte[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= StStop;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        StStop: begin
          if (r_clk_cnt == LastCnt) begin
            // Leave at mid-stop-bit so a back-to-back start edge is not missed.
            r_clk_cnt <= '0;
            r_state   <= StIdle;
            if (w_rxs) begin
              r_word       <= {r_word[15:0], r_byte};
              r_byte_count <= r_byte_count + 2'd1;
              if (r_byte_count == 2'd3) begin
                r_nonce <= {r_word, r_byte};
                r_valid <= 1'b1;
              end
            end else begin
              r_ferr       <= 1'b1;
              r_byte_count <= '0;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.nonceIn    = r_nonce;
  assign bus.nonceValid = r_valid;
  assign bus.frameError = r_ferr;
  assign bus.busy       = (r_state != StIdle) || (r_byte_count != 2'd0);

endmodule

// File: tb/tb_nonce_uart_rx.sv
// Bench for nonce_uart_rx: drives rx serially with time delays and compares received
// nonces and error pulses against a byte-level word-assembly model.
module tb_nonce_uart_rx;
  localparam int unsigned Cpb = 8;
  localparam int unsigned Gap = 200;
  localparam int          Clk = 10;
  localparam int          BitT = Cpb * Clk;

  logic clock = 1'b0;
  logic reset = 1'b0;
  nonce_uart_rx_if ifc ();

  nonce_uart_rx #(.CLKS_PER_BIT(Cpb), .GAP_CLKS(Gap)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  always #(Clk / 2) clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errs   = 0;

  // Observations
  logic [31:0] got_q[$];
  int          got_t[$];
  int          fe_cnt = 0;
  int          n_long = 0;
  logic        prev_v = 1'b0;
  logic        prev_f = 1'b0;

  always @(negedge clock) begin
    if (ifc.nonceValid) begin
      got_q.push_back(ifc.nonceIn);
      got_t.push_back(cyc);
    end
    if (ifc.frameError) fe_cnt++;
    if ((ifc.nonceValid && prev_v) || (ifc.frameError && prev_f)) n_long++;
    prev_v = ifc.nonceValid;
    prev_f = ifc.frameError;
  end

  // Reference model: bytes accumulate into a word; bad stop or long idle restarts it.
  logic [31:0] exp_q[$];
  int          exp_fe = 0;
  int          m_cnt  = 0;
  int          m_idle = 0;
  logic [31:0] m_word = '0;
  logic [31:0] m_last = '0;
  int          last_fall = 0;

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (m_idle >= 150) m_cnt = 0;
    m_idle = 0;
    if (ok) begin
      m_word = {m_word[23:0], b};
      m_cnt++;
      if (m_cnt == 4) begin
        exp_q.push_back(m_word);
        m_last = m_word;
        m_cnt  = 0;
      end
    end else begin
      m_cnt = 0;
      exp_fe++;
    end
  endtask

  task automatic idle_cycles(input int n);
    #(n * Clk);
    m_idle += n;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok, input int bit_t);
    last_fall = cyc;
    ifc.rx = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      ifc.rx = b[i];
      #(bit_t);
    end
    ifc.rx = ok;
    #(bit_t);
    ifc.rx = 1'b1;
  endtask

  task automatic xmit(input logic [7:0] b, input bit ok, input int idle, input int bit_t);
    idle_cycles(idle);
    model_byte(b, ok);
    send_byte(b, ok, bit_t);
  endtask

  task automatic clear_obs();
    got_q.delete();
    got_t.delete();
    exp_q.delete();
    fe_cnt = 0;
    exp_fe = 0;
    n_long = 0;
  endtask

  task automatic test_reset();
    #1;
    n_checks += 4;
    if (ifc.nonceIn !== 32'h0) begin
      n_errs++; $display("FAIL reset_nonce: got %h expected 0", ifc.nonceIn);
    end
    if (ifc.nonceValid !== 1'b0) begin
      n_errs++; $display("FAIL reset_valid: got %b expected 0", ifc.nonceValid);
    end
    if (ifc.frameError !== 1'b0) begin
      n_errs++; $display("FAIL reset_ferr: got %b expected 0", ifc.frameError);
    end
    if (ifc.busy !== 1'b0) begin
      n_errs++; $display("FAIL reset_busy: got %b expected 0", ifc.busy);
    end
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    n_checks += 2;
    if (ifc.busy !== 1'b0) begin
      n_errs++; $display("FAIL post_reset_busy: got %b expected 0", ifc.busy);
    end
    if (ifc.nonceIn !== 32'h0) begin
      n_errs++; $display("FAIL post_reset_nonce: got %h expected 0", ifc.nonceIn);
    end
  endtask

  task automatic test_single_word();
    int lat;
    clear_obs();
    xmit(8'h42, 1'b1, 5, BitT);
    xmit(8'hA1, 1'b1, 0, BitT);
    xmit(8'h46, 1'b1, 0, BitT);
    xmit(8'h93, 1'b1, 0, BitT);
    idle_cycles(20);
    lat = (got_t.size() > 0) ? got_t[0] - last_fall : -1;
    n_checks += 6;
    if (got_q.size() != 1) begin
      n_errs++; $display("FAIL single_count: got %0d expected 1", got_q.size());
    end
    if (((got_q.size() > 0) ? got_q[0] : 32'hx) !== 32'h42A14693) begin
      n_errs++; $display("FAIL single_value: got %h expected 42a14693",
                         (got_q.size() > 0) ? got_q[0] : 32'hx);
    end
    if (fe_cnt != 0) begin
      n_errs++; $display("FAIL single_ferr: got %0d expected 0", fe_cnt);
    end
    if (ifc.busy !== 1'b0) begin
      n_errs++; $display("FAIL single_busy: got %b expected 0", ifc.busy);
    end
    if (lat < 10 * Cpb - 1 || lat > 10 * Cpb + 1) begin
      n_errs++; $display("FAIL single_latency: got %0d expected %0d+-1", lat, 10 * Cpb);
    end
    if (n_long != 0) begin
      n_errs++; $display("FAIL single_pulse_width: got %0d long pulses expected 0", n_long);
    end
  endtask

  task automatic test_frame_error();
    clear_obs();
    xmit(8'h42, 1'b1, 5, BitT);
    xmit(8'hA1, 1'b0, 0, BitT);
    xmit(8'hDE, 1'b1, 10, BitT);
    xmit(8'hAD, 1'b1, 0, BitT);
    xmit(8'hBE, 1'b1, 0, BitT);
    xmit(8'hEF, 1'b1, 0, BitT);
    idle_cycles(20);
    n_checks += 5;
    if (fe_cnt != exp_fe) begin
      n_errs++; $display("FAIL ferr_count: got %0d expected %0d", fe_cnt, exp_fe);
    end
    if (got_q.size() != exp_q.size()) begin
      n_errs++; $display("FAIL ferr_words: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    if (((got_q.size() > 0) ? got_q[0] : 32'hx) !== 32'hDEADBEEF) begin
      n_errs++; $display("FAIL ferr_value: got %h expected deadbeef",
                         (got_q.size() > 0) ? got_q[0] : 32'hx);
    end
    if (ifc.busy !== 1'b0) begin
      n_errs++; $display("FAIL ferr_busy: got %b expected 0", ifc.busy);
    end
    if (n_long != 0) begin
      n_errs++; $display("FAIL ferr_pulse_width: got %0d long pulses expected 0", n_long);
    end
  endtask

  task automatic test_glitch();
    clear_obs();
    ifc.rx = 1'b0;
    #(2 * Clk);
    ifc.rx = 1'b1;
    idle_cycles(30);
    n_checks += 4;
    if (got_q.size() != 0) begin
      n_errs++; $display("FAIL glitch_valid: got %0d pulses expected 0", got_q.size());
    end
    if (fe_cnt != 0) begin
      n_errs++; $display("FAIL glitch_ferr: got %0d pulses expected 0", fe_cnt);
    end
    if (ifc.nonceIn !== m_last) begin
      n_errs++; $display("FAIL glitch_nonce: got %h expected %h", ifc.nonceIn, m_last);
    end
    if (ifc.busy !== 1'b0) begin
      n_errs++; $display("FAIL glitch_busy: got %b expected 0", ifc.busy);
    end
  endtask

  task automatic test_gap_timeout();
    clear_obs();
    xmit(8'h11, 1'b1, 5, BitT);
    xmit(8'h22, 1'b1, 0, BitT);
    idle_cycles(50);
    n_checks++;
    if (ifc.busy !== 1'b1) begin
      n_errs++; $display("FAIL gap_busy_held: got %b expected 1", ifc.busy);
    end
    idle_cycles(250);
    n_checks++;
    if (ifc.busy !== 1'b0) begin
      n_errs++; $display("FAIL gap_busy_dropped: got %b expected 0", ifc.busy);
    end
    xmit(8'h42, 1'b1, 0, BitT);
    xmit(8'hA1, 1'b1, 0, BitT);
    xmit(8'h46, 1'b1, 0, BitT);
    xmit(8'h93, 1'b1, 0, BitT);
    idle_cycles(20);
    n_checks += 3;
    if (got_q.size() != 1) begin
      n_errs++; $display("FAIL gap_count: got %0d expected 1", got_q.size());
    end
    if (((got_q.size() > 0) ? got_q[0] : 32'hx) !== 32'h42A14693) begin
      n_errs++; $display("FAIL gap_value: got %h expected 42a14693",
                         (got_q.size() > 0) ? got_q[0] : 32'hx);
    end
    if (fe_cnt != 0) begin
      n_errs++; $display("FAIL gap_ferr: got %0d expected 0", fe_cnt);
    end
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] part;
    logic [7:0] bytes [4];
    logic [31:0] want;
    clear_obs();
    part = 8'hC3;
    xmit(8'h5A, 1'b1, 5, BitT);
    ifc.rx = 1'b0;
    #(BitT);
    for (int i = 0; i < 3; i++) begin
      ifc.rx = part[i];
      #(BitT);
    end
    #(3 * Clk);
    reset = 1'b0;
    #1;
    n_checks += 4;
    if (ifc.nonceIn !== 32'h0) begin
      n_errs++; $display("FAIL rst_mid_nonce: got %h expected 0", ifc.nonceIn);
    end
    if (ifc.nonceValid !== 1'b0) begin
      n_errs++; $display("FAIL rst_mid_valid: got %b expected 0", ifc.nonceValid);
    end
    if (ifc.frameError !== 1'b0) begin
      n_errs++; $display("FAIL rst_mid_ferr: got %b expected 0", ifc.frameError);
    end
    if (ifc.busy !== 1'b0) begin
      n_errs++; $display("FAIL rst_mid_busy: got %b expected 0", ifc.busy);
    end
    ifc.rx = 1'b1;
    m_cnt  = 0;
    m_idle = 0;
    m_last = '0;
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;
    idle_cycles(10);
    for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom);
    want = {bytes[0], bytes[1], bytes[2], bytes[3]};
    for (int i = 0; i < 4; i++) xmit(bytes[i], 1'b1, 0, BitT);
    idle_cycles(20);
    n_checks += 3;
    if (got_q.size() != 1) begin
      n_errs++; $display("FAIL rst_mid_count: got %0d expected 1", got_q.size());
    end
    if (((got_q.size() > 0) ? got_q[0] : 32'hx) !== want) begin
      n_errs++; $display("FAIL rst_mid_value: got %h expected %h",
                         (got_q.size() > 0) ? got_q[0] : 32'hx, want);
    end
    if (ifc.busy !== 1'b0) begin
      n_errs++; $display("FAIL rst_mid_busy_after: got %b expected 0", ifc.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bb [8];
    int sp;
    bb = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    clear_obs();
    for (int i = 0; i < 8; i++) xmit(bb[i], 1'b1, (i == 0) ? 5 : 0, BitT);
    idle_cycles(20);
    sp = (got_t.size() > 1) ? got_t[1] - got_t[0] : -1;
    n_checks += 5;
    if (got_q.size() != 2) begin
      n_errs++; $display("FAIL b2b_count: got %0d expected 2", got_q.size());
    end
    if (((got_q.size() > 0) ? got_q[0] : 32'hx) !== 32'h00000001) begin
      n_errs++; $display("FAIL b2b_first: got %h expected 00000001",
                         (got_q.size() > 0) ? got_q[0] : 32'hx);
    end
    if (((got_q.size() > 1) ? got_q[1] : 32'hx) !== 32'hFFFFFFFF) begin
      n_errs++; $display("FAIL b2b_second: got %h expected ffffffff",
                         (got_q.size() > 1) ? got_q[1] : 32'hx);
    end
    if (sp < 40 * Cpb - 2 || sp > 40 * Cpb + 2) begin
      n_errs++; $display("FAIL b2b_spacing: got %0d expected %0d+-2", sp, 40 * Cpb);
    end
    if (ifc.nonceIn !== 32'hFFFFFFFF) begin
      n_errs++; $display("FAIL b2b_hold: got %h expected ffffffff", ifc.nonceIn);
    end
  endtask

  task automatic test_random();
    bit ok;
    bit prev_bad;
    int idle;
    clear_obs();
    prev_bad = 1'b0;
    for (int n = 0; n < 28; n++) begin
      ok = ($urandom_range(7) != 0);
      if ($urandom_range(6) == 0) idle = 300;
      else idle = prev_bad ? 10 + int'($urandom_range(30)) : int'($urandom_range(40));
      xmit(8'($urandom), ok, idle, BitT + int'($urandom_range(2)));
      prev_bad = !ok;
    end
    idle_cycles(30);
    n_checks += 3;
    if (got_q.size() != exp_q.size()) begin
      n_errs++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    if (fe_cnt != exp_fe) begin
      n_errs++; $display("FAIL rand_ferr: got %0d expected %0d", fe_cnt, exp_fe);
    end
    if (n_long != 0) begin
      n_errs++; $display("FAIL rand_pulse_width: got %0d long pulses expected 0", n_long);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (((i < got_q.size()) ? got_q[i] : 32'hx) !== exp_q[i]) begin
        n_errs++; $display("FAIL rand_word%0d: got %h expected %h", i,
                           (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]);
      end
    end
  endtask

  initial begin
    ifc.rx = 1'b1;
    test_reset();
    @(posedge clock);
    #1;
    test_single_word();
    test_frame_error();
    test_glitch();
    test_gap_timeout();
    test_reset_mid_byte();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/nonce_uart_rx.md
# nonce_uart_rx

Serial receiver that accepts 32-bit nonce seeds from the host PC over a UART line and presents each one to the processor as `nonceIn`, replacing the fixed constant. Runs on the mining clock domain. It deserialises 8N1 bytes, assembles four bytes big-endian into one word, and signals each completed word with a single-cycle strobe. Malformed frames and stalled partial words are discarded, so the word boundary always resynchronises.

## Interface
- `CLKS_PER_BIT`, default 289: clock cycles per UART bit (33.3 MHz / 115200 baud); must be ≥ 4.
- `GAP_CLKS`, default 100000: idle cycles after which a partial word is discarded.
- `clock` input, 1 bit: single clock; all logic is on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `rx` input, 1 bit: UART serial data; idles high; asynchronous to `clock`.
- `nonceIn` output, 32 bits: last complete word received; holds its value until the next word completes.
- `nonceValid` output, 1 bit: one-cycle pulse when `nonceIn` is updated.
- `frameError` output, 1 bit: one-cycle pulse when a stop bit is sampled low.
- `busy` output, 1 bit: high while the FSM is outside IDLE or while a partial word is held.

## Operation
- **Input synchroniser.** `rx` passes through a 2-flop synchroniser; both flops reset to 1. All decisions use the synchronised signal `rxs`.
- **FSM states.** IDLE, START, DATA, STOP.
- **IDLE.** When `rxs` is 0, clear the bit counter and go to START.
- **START.**
  - Wait until `CLKS_PER_BIT/2` cycles have elapsed (integer divide).
  - Sample `rxs`. If it is 1, treat it as a glitch and return to IDLE with no outputs. If it is 0, reset the bit counter and go to DATA.
- **DATA.**
  - Sample `rxs` every `CLKS_PER_BIT` cycles, 8 samples in total.
  - Data is LSB first and shifts into the byte register at bit 7.
  - After the 8th sample, go to STOP.
- **STOP.**
  - Sample after a further `CLKS_PER_BIT` cycles.
  - Stop bit = 1: append the byte with `word <= {word[23:0], byte}` and increment `byteCount` (2 bits).
    - If `byteCount` was 3, load `nonceIn <= {word[23:0], byte}`, pulse `nonceValid`, and set `byteCount` to 0.
  - Stop bit = 0: pulse `frameError`, discard the partial word (`byteCount <= 0`), and do not update `nonceIn`.
  - Always return to IDLE immediately after the stop sample, at mid-stop-bit. This allows a back-to-back start bit to be detected.
- **Byte order.** The first byte received becomes `nonceIn[31:24]`.
- **Gap timeout.**
  - A gap counter runs only in IDLE while `byteCount != 0`. It clears on leaving IDLE.
  - When it reaches `GAP_CLKS`, set `byteCount <= 0` with no pulse.
- **Simultaneous events.** A stop-bit completion and a gap timeout cannot coincide, because the gap counter is not running outside IDLE.
- **Reset values.** `nonceIn` = 32'h0, `nonceValid` = 0, `frameError` = 0, `busy` = 0. FSM = IDLE; all counters, `byteCount` and `word` = 0.
- **Reset mid-operation.** Asserting `reset` during a byte abandons it entirely. After release, reception restarts at the next falling edge of `rxs`.

## Timing
- **Input delay.** `rxs` lags `rx` by 2 cycles.
- **Start detection.** The falling edge is recognised in the cycle `rxs` first reads 0.
- **Sample points**, counted from the cycle of entry to START:
  - start-bit check at cycle `CLKS_PER_BIT/2`;
  - data bit k (k = 0..7) at `CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT`;
  - stop bit at `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT`.
- **Output latency.** `nonceValid` and `frameError` assert in the cycle after the stop sample and last exactly 1 cycle. `nonceIn` changes in the same cycle that `nonceValid` is high.
- **Back-to-back words.** Consecutive words produce pulses at least `10*CLKS_PER_BIT - CLKS_PER_BIT/2` cycles apart. No word is dropped.
- **Baud tolerance.** Reception is correct with ±3% baud mismatch.

## Test plan
For every scenario, use `CLKS_PER_BIT=8` and `GAP_CLKS=200`.
- **Single word.** Send bytes 42, A1, 46, 93 → one `nonceValid` pulse, `nonceIn` = 32'h42A14693, `frameError` never high, `busy` = 0 afterwards.
- **Framing error.**
  - Send 42, then A1 with a low stop bit → `frameError` pulses once and there is no `nonceValid`.
  - Then send DE, AD, BE, EF → `nonceIn` = 32'hDEADBEEF.
- **Glitch rejection.** Drive `rx` low for 2 cycles, then high → FSM stays in IDLE, no pulses, `nonceIn` unchanged.
- **Gap timeout.** Send 11, 22, idle for 300 cycles, then send 42, A1, 46, 93 → `nonceIn` = 32'h42A14693 (not 32'h112242A1).
- **Reset mid-byte.**
  - Assert `reset` during the data bits of the second byte → all outputs read 0 immediately.
  - After release, send 4 clean bytes → a correct word is received.
- **Back-to-back words.** Send 8 bytes with no idle time: 00 00 00 01 FF FF FF FF → two pulses, `nonceIn` = 32'h00000001 and then 32'hFFFFFFFF.
